// File: rtl/reg_file_32x32_pkg.sv
// Shared sizing constants and dump-state encoding for the 32x32 register file.
package reg_file_32x32_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } dump_state_e;

endpackage

// File: rtl/reg_file_32x32_dump_fsm.sv
// Dump sequencer: IDLE waits for dumpStart; DUMP streams indices 0..2**ADDR_W-1
// on consecutive cycles, then returns to IDLE. Requests made during DUMP are dropped.
module reg_dump_fsm #(
    parameter int ADDR_W = reg_file_32x32_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dumpStart,
    output logic              dumpBusy,
    output logic              dumpValid,
    output logic [ADDR_W-1:0] dumpIdx
);
    import reg_file_32x32_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = '0;
        dumpBusy  = 1'b0;
        dumpValid = 1'b0;
        case (state_q)
            IDLE: begin
                if (dumpStart) begin
                    state_d = DUMP;
                end
            end
            DUMP: begin
                dumpBusy  = 1'b1;
                dumpValid = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dumpIdx = idx_q;

endmodule

// File: rtl/reg_file_32x32.sv
// Two-read/one-write register file with hard-wired zero register, write-through
// bypass on the read ports and a sequential dump port for the whole array.
module reg_file_32x32 #(
    parameter int DATA_W = reg_file_32x32_pkg::DATA_W,
    parameter int ADDR_W = reg_file_32x32_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              dumpStart,
    output logic              dumpBusy,
    output logic              dumpValid,
    output logic [ADDR_W-1:0] dumpIdx,
    output logic [DATA_W-1:0] dumpData
);
    import reg_file_32x32_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_en;

    assign wr_en = regWrite && (writeReg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[writeReg] <= writeData;
        end
    end

    // Index 0 is forced to zero here so no path can ever leak a stored value.
    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] idx);
        return (idx == '0) ? '0 : regs_q[idx];
    endfunction

    assign readData1 = (wr_en && (writeReg == readReg1)) ? writeData : stored(readReg1);
    assign readData2 = (wr_en && (writeReg == readReg2)) ? writeData : stored(readReg2);

    reg_dump_fsm #(
        .ADDR_W (ADDR_W)
    ) u_dump_fsm (
        .clk       (clk),
        .reset     (reset),
        .dumpStart (dumpStart),
        .dumpBusy  (dumpBusy),
        .dumpValid (dumpValid),
        .dumpIdx   (dumpIdx)
    );

    // The dump port shows stored contents only; bypass is deliberately excluded.
    assign dumpData = dumpValid ? stored(dumpIdx) : '0;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Bench for reg_file_32x32: directed vector table, dump sequences and a
// randomized run checked against an array-based reference model.
module tb_reg_file_32x32;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readReg1, readReg2, writeReg, dumpIdx;
    logic [31:0] readData1, readData2, writeData, dumpData;
    logic        regWrite, dumpStart, dumpBusy, dumpValid;

    always #5 clk = ~clk;

    reg_file_32x32 dut (
        .clk       (clk),
        .reset     (reset),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .dumpStart (dumpStart),
        .dumpBusy  (dumpBusy),
        .dumpValid (dumpValid),
        .dumpIdx   (dumpIdx),
        .dumpData  (dumpData)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m [32];
    bit          dump_on;
    int          dpos;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] r);
        if (regWrite && writeReg != 5'd0 && writeReg == r) return writeData;
        return m[r];
    endfunction

    task automatic check_all();
        chk("readData1", readData1, exp_read(readReg1));
        chk("readData2", readData2, exp_read(readReg2));
        chk("dumpBusy",  {31'b0, dumpBusy},  {31'b0, dump_on});
        chk("dumpValid", {31'b0, dumpValid}, {31'b0, dump_on});
        chk("dumpIdx",   {27'b0, dumpIdx},   dump_on ? 32'(dpos) : 32'd0);
        chk("dumpData",  dumpData,           dump_on ? m[dpos] : 32'd0);
    endtask

    // Advance the reference model by one clock using the current inputs, then clock the DUT.
    task automatic cycle();
        if (reset) begin
            foreach (m[i]) m[i] = 32'd0;
            dump_on = 1'b0;
            dpos    = 0;
        end else begin
            if (regWrite && writeReg != 5'd0) m[writeReg] = writeData;
            if (dump_on) begin
                if (dpos == 31) begin
                    dump_on = 1'b0;
                    dpos    = 0;
                end else begin
                    dpos++;
                end
            end else if (dumpStart) begin
                dump_on = 1'b1;
                dpos    = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 32'h0,         32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 5'd7, 32'hA5A5_A5A5, 5'd5, 5'd7, 32'hDEAD_BEEF, 32'hA5A5_A5A5};
        vecs[5] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[6] = '{1'b1, 5'd7, 32'h0F0F_0F0F, 5'd7, 5'd6, 32'h0F0F_0F0F, 32'h0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd1, 32'h0F0F_0F0F, 32'h0};

        reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = '0; readReg2 = '0; dumpStart = 1'b0;
        foreach (m[i]) m[i] = 32'd0;
        dump_on = 1'b0;
        dpos    = 0;
        #2;
        cycle();
        cycle();
        reset = 1'b0;

        // All registers read zero after reset
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i);
            readReg2 = 5'(31 - i);
            #1;
            chk($sformatf("post_reset_r1[%0d]", i), readData1, 32'h0);
            chk($sformatf("post_reset_r2[%0d]", 31 - i), readData2, 32'h0);
        end
        check_all();

        // Directed write/read/bypass vectors
        for (int v = 0; v < 8; v++) begin
            regWrite = vecs[v].we; writeReg = vecs[v].wreg; writeData = vecs[v].wdata;
            readReg1 = vecs[v].r1; readReg2 = vecs[v].r2;
            #1;
            chk($sformatf("vec%0d_rd1", v), readData1, vecs[v].exp1);
            chk($sformatf("vec%0d_rd2", v), readData2, vecs[v].exp2);
            cycle();
        end
        regWrite = 1'b0;

        // Preload i*4 and run a full dump with a stray dumpStart at index 10
        for (int i = 1; i < 32; i++) begin
            regWrite = 1'b1; writeReg = 5'(i); writeData = 32'(i * 4);
            cycle();
        end
        regWrite = 1'b0;
        dumpStart = 1'b1;
        #1;
        chk("idle_busy_before_start", {31'b0, dumpBusy}, 32'd0);
        chk("idle_data_before_start", dumpData, 32'd0);
        cycle();
        for (int k = 0; k < 32; k++) begin
            dumpStart = (k == 10);
            #1;
            chk($sformatf("dump_valid[%0d]", k), {31'b0, dumpValid}, 32'd1);
            chk($sformatf("dump_busy[%0d]", k),  {31'b0, dumpBusy},  32'd1);
            chk($sformatf("dump_idx[%0d]", k),   {27'b0, dumpIdx},   32'(k));
            chk($sformatf("dump_data[%0d]", k),  dumpData,           32'(k * 4));
            cycle();
        end
        dumpStart = 1'b0;
        #1;
        chk("dump_end_busy",  {31'b0, dumpBusy},  32'd0);
        chk("dump_end_valid", {31'b0, dumpValid}, 32'd0);
        chk("dump_end_idx",   {27'b0, dumpIdx},   32'd0);
        chk("dump_end_data",  dumpData,           32'd0);
        cycle();
        chk("no_queued_restart", {31'b0, dumpBusy}, 32'd0);

        // Reset at dumpIdx=12 aborts the dump and wins over write/start
        dumpStart = 1'b1;
        cycle();
        dumpStart = 1'b0;
        repeat (12) cycle();
        chk("pre_abort_idx", {27'b0, dumpIdx}, 32'd12);
        reset = 1'b1; regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hFFFF_FFFF; dumpStart = 1'b1;
        cycle();
        reset = 1'b0; regWrite = 1'b0; dumpStart = 1'b0;
        #1;
        chk("abort_valid", {31'b0, dumpValid}, 32'd0);
        chk("abort_busy",  {31'b0, dumpBusy},  32'd0);
        chk("abort_idx",   {27'b0, dumpIdx},   32'd0);
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i);
            readReg2 = 5'(i);
            #1;
            chk($sformatf("abort_clear_r1[%0d]", i), readData1, 32'h0);
            chk($sformatf("abort_clear_r2[%0d]", i), readData2, 32'h0);
        end

        // Randomized traffic including writes during dumps, bypass hits and resets
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            regWrite  = 1'($urandom_range(0, 1));
            writeReg  = 5'($urandom_range(0, 31));
            writeData = $urandom;
            readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            readReg2  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            dumpStart = ($urandom_range(0, 15) == 0);
            #1;
            check_all();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_32x32.md
REG_FILE_32X32 -- requirements
Module: reg_file_32x32

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register width and the width of all data ports.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register index width; register count is 2**ADDR_W = 32.
REQ-003 Clock and reset: one clock, reset synchronous, active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 readReg1  input  5  read port 1 index.
REQ-007 readReg2  input  5  read port 2 index.
REQ-008 readData1  output  32  read port 1 data.
REQ-009 readData2  output  32  read port 2 data.
REQ-010 regWrite  input  1  write enable.
REQ-011 writeReg  input  5  write index.
REQ-012 writeData  input  32  write data.
REQ-013 dumpStart  input  1  single-cycle request to stream all registers.
REQ-014 dumpBusy  output  1  dump sequence in progress.
REQ-015 dumpValid  output  1  dumpIdx/dumpData valid this cycle.
REQ-016 dumpIdx  output  5  index of the register being streamed.
REQ-017 dumpData  output  32  contents of register dumpIdx.

Function
REQ-018 Write: on a rising edge with regWrite=1 and writeReg!=0, register[writeReg] SHALL take writeData; writes to index 0 SHALL be discarded.
REQ-019 Register 0 SHALL always read as 32'h0 on every read and dump port.
REQ-020 Reads SHALL be combinational: readDataN = register[readRegN], zero latency.
REQ-021 Bypass: when regWrite=1, writeReg!=0 and writeReg==readRegN in the same cycle, readDataN SHALL equal writeData, not the stale stored value.
REQ-022 Dump FSM states: IDLE, DUMP.
REQ-023 IDLE -> DUMP on a rising edge with dumpStart=1; dumpIdx SHALL be 0 in the first DUMP cycle.
REQ-024 In DUMP, dumpBusy=1 and dumpValid=1 every cycle; dumpIdx SHALL increment by 1 per cycle, with no gaps.
REQ-025 DUMP -> IDLE on the edge ending the dumpIdx=31 cycle; a dump SHALL last exactly 32 cycles; dumpIdx SHALL return to 0.
REQ-026 dumpStart asserted while in DUMP SHALL be ignored; no restart and no queuing.
REQ-027 dumpData SHALL equal the stored (pre-write, non-bypassed) value of register[dumpIdx] in that cycle.
REQ-028 A write landing during a dump SHALL be visible to a later dump index only if it targets an index not yet streamed.
REQ-029 In IDLE, dumpValid=0, dumpBusy=0, dumpIdx=0, dumpData=32'h0.
REQ-030 Normal reads and writes SHALL be unaffected by dump activity.

Reset
REQ-031 When reset=1 at a rising edge, all 32 registers SHALL become 32'h0, the FSM SHALL enter IDLE, and dumpIdx SHALL become 0.
REQ-032 Reset SHALL take priority over regWrite and dumpStart in the same cycle.
REQ-033 Reset during DUMP SHALL abort the dump: dumpValid=0 from the next cycle, with no further indices streamed.
REQ-034 After reset, readData1 and readData2 SHALL be 32'h0 for any index until written.

Structure
REQ-035 A shared package SHALL hold NUM_REGS=32, ADDR_W=5, DATA_W=32 and the dump-state enum {IDLE, DUMP}.
REQ-036 The dump FSM and its index counter SHALL be one sub-module, reg_dump_fsm; the storage array, write logic and read/bypass logic stay in the top module.

Verification
REQ-037 Reset; then read indices 0..31 on both ports -> all return 32'h0.
REQ-038 Write 32'hDEAD_BEEF to index 5; next cycle set readReg1=5 -> readData1=32'hDEAD_BEEF. Write 32'h1234_5678 to index 0 -> index 0 still reads 32'h0.
REQ-039 Same cycle: regWrite=1, writeReg=7, writeData=32'hA5A5_A5A5, readReg2=7 -> readData2=32'hA5A5_A5A5 in that cycle.
REQ-040 Preload register[i]=i*4 for i=1..31; pulse dumpStart -> 32 consecutive dumpValid cycles, dumpIdx=0..31, dumpData=0,4,...,124; then dumpBusy=0.
REQ-041 Pulse dumpStart again at dumpIdx=10 -> no restart; total dump remains 32 cycles.
REQ-042 Assert reset at dumpIdx=12 -> next cycle dumpValid=0 and dumpIdx=0, and all registers read 32'h0.
